// File: rtl/mc_word_memory_if.sv
// Core-to-memory port bundle for the multi-cycle core's data/instruction memory.
// The core drives level strobes and the address/data; the memory answers with data and flags.
interface mc_word_memory_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_addr,
    output mem_write_data,
    output mem_read,
    output mem_write,
    input  mem_read_data,
    input  mem_ready,
    input  mem_error
  );

  modport slave (
    input  mem_addr,
    input  mem_write_data,
    input  mem_read,
    input  mem_write,
    output mem_read_data,
    output mem_ready,
    output mem_error
  );
endinterface

// File: rtl/mc_word_memory.sv
// Word-organised memory behind the multi-cycle core, with fixed read/write
// latency, a completion flag and a sticky per-access error flag.
module mc_word_memory #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  mc_word_memory_if.slave bus
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] idx_q, idx_n;
  logic [31:0]           wdata_q, wdata_n;
  logic                  err_q, err_n;
  logic [31:0]           rdata, rdata_n;
  logic                  ready, ready_n;
  logic                  error, error_n;
  logic                  we;

  logic [31:0] mem [DEPTH];

  logic req;
  logic both;
  logic bad_align;
  logic bad_range;
  logic cap_err;

  assign req       = bus.mem_read | bus.mem_write;
  assign both      = bus.mem_read & bus.mem_write;
  assign bad_align = |bus.mem_addr[1:0];
  // Any byte address beyond the array, including bits above the index.
  assign bad_range = |(bus.mem_addr >> (ADDR_WIDTH + 2));
  assign cap_err   = bad_align | bad_range | both;

  assign bus.mem_read_data = rdata;
  assign bus.mem_ready     = ready;
  assign bus.mem_error     = error;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx_q;
    wdata_n = wdata_q;
    err_n   = err_q;
    rdata_n = rdata;
    ready_n = ready;
    error_n = error;
    we      = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          idx_n   = bus.mem_addr[ADDR_WIDTH+1:2];
          wdata_n = bus.mem_write_data;
          err_n   = cap_err;
          cnt_n   = 4'd1;
          state_n = bus.mem_write ? WR_WAIT : RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (cnt == RD_LAT) begin
          rdata_n = err_q ? 32'd0 : mem[idx_q];
          error_n = err_q;
          ready_n = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      WR_WAIT: begin
        if (cnt == WR_LAT) begin
          we      = ~err_q;
          error_n = err_q;
          ready_n = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      DONE: begin
        // Held strobes keep us here so one request never re-triggers.
        if (!req) begin
          ready_n = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx_q   <= idx_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
      rdata   <= rdata_n;
      ready   <= ready_n;
      error   <= error_n;
    end
  end

  // Array has no reset; reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/mc_word_memory.md
Name: mc_word_memory

Overview:
- Word-organised data/instruction memory sitting directly downstream of the multi-cycle MIPS core's memory ports.
- Consumes the core's level-held mem_read/mem_write strobes, byte address and write data.
- Returns registered read data after a configurable latency.
- Adds a completion flag and an access-error flag for the bench/controller.

Parameters:
ADDR_WIDTH, 10, word-address bits (depth = 2**ADDR_WIDTH words)
READ_LATENCY, 1, cycles from request capture to read data valid (range 1..15)
WRITE_LATENCY, 1, cycles from request capture to array commit (range 1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
mem_addr  input  32  byte address from core MAR
mem_write_data  input  32  store data from core B register
mem_read  input  1  level read request
mem_write  input  1  level write request
mem_read_data  output  32  registered read data
mem_ready  output  1  access complete; high for every cycle in DONE
mem_error  output  1  sticky error flag for the last access

Behaviour:
- Reset: one clock; reset asynchronous and active-low. While low, state=IDLE, counter=0, mem_read_data=0, mem_ready=0, mem_error=0. Array contents are NOT reset.
- Reset asserted mid-access aborts the access; a pending write is not committed.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, capture rule: on a clock edge with mem_write=1 or mem_read=1, latch the following, load counter=1, and go to WR_WAIT (mem_write) else RD_WAIT:
  - mem_addr into addr_q;
  - mem_write_data into wdata_q;
  - the error decision into err_q.
  - This edge is "capture edge k".
- Priority: mem_write and mem_read both high -> treated as a write, and err_q=1.
- Error decision at capture: err_q=1 if any of:
  - mem_addr[1:0]!=0;
  - mem_addr[31:ADDR_WIDTH+2]!=0;
  - both strobes high.
- Word index = addr_q[ADDR_WIDTH+1:2].
- RD_WAIT: counter increments each edge. When counter==READ_LATENCY at an edge:
  - mem_read_data <= (err_q ? 0 : array[index]);
  - mem_error <= err_q;
  - mem_ready <= 1;
  - go to DONE.
  - Result: data valid after edge k+READ_LATENCY.
- WR_WAIT: when counter==WRITE_LATENCY at an edge:
  - array[index] <= wdata_q unless err_q (write suppressed);
  - mem_error <= err_q;
  - mem_ready <= 1;
  - go to DONE.
  - mem_read_data unchanged by writes.
- Strobe drop mid-access: deasserting the strobe before completion does not abort. The access completes normally.
- Post-capture input changes: mem_addr/mem_write_data changes after capture are ignored.
- DONE:
  - mem_ready=1, mem_read_data held.
  - Leave to IDLE on the first edge where mem_read=0 and mem_write=0. mem_ready clears on that same edge.
  - DONE lasts at least 1 cycle. A strobe held continuously never re-triggers; the core must drop it for at least one edge between accesses.
- mem_error:
  - updated only at completion;
  - holds until the next completion or reset.
- Timing fit with the core: with READ_LATENCY=1, a read captured at the end of FETCH1 is valid before the FETCH3 sampling edge. LW and SW sequences fit the same way.
- Counter: 4 bits; it never wraps, because the latency parameters are ≤15.
- Read-after-write: a read captured any edge after the write's completion returns the new data.

Test Plan:
- Reset low for 2 cycles mid RD_WAIT -> mem_ready=0, mem_read_data=0, mem_error=0 immediately (asynchronous); next read of a preloaded word still returns the preloaded value.
- Write 0xDEADBEEF to addr 0x10 (strobe 1 cycle), then read 0x10 with READ_LATENCY=1 -> mem_ready rises after edge k+1, mem_read_data=0xDEADBEEF, mem_error=0.
- READ_LATENCY=3, read addr 0x4, mem_read dropped after 1 cycle -> data still appears after edge k+3; mem_ready held 1 cycle only, then IDLE.
- Read addr 0x13 (misaligned) and addr 0x00001000 with ADDR_WIDTH=10 (out of range) -> mem_read_data=0, mem_error=1. A following write to 0x1000 leaves word 0 unchanged.
- mem_read=mem_write=1 at addr 0x8 with data 0x12345678 -> no array change, mem_error=1. A following read of 0x8 returns the old value with mem_error=0.
- mem_read held high for 10 cycles -> exactly one access; mem_ready stays 1 from completion until the strobe drops, and no second capture occurs.
